dmem_pipe: RTL and testbench

- Parametrised successor to the core's flat byte-array RAM: a data memory with a valid/ready request channel and a response channel.
- Supports byte, half and word accesses with sign or zero extension, and a configurable read latency.
- Flags misaligned and out-of-range accesses instead of corrupting memory.
- Sits between the MEM stage and storage; byte order is big-endian: byte at addr is the MSB of the word.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_align.sv | 67 ++++++
 rtl/dmem_pipe.sv | 114 +++++++++++
 tb/tb_dmem_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the pipelined data memory
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   err;
  } dmem_rsp_t;

  function automatic logic [2:0] size_bytes(mem_size_e s);
    case (s)
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - access checking, store lane steering and load extension
module dmem_align
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 4096
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [31:0]       i_wdata,
  input  logic [31:0]       i_raw,
  output logic              o_err,
  output logic [3:0]        o_be,
  output logic [31:0]       o_wlane,
  output logic [31:0]       o_rdata
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH_BYTES);

  logic [ADDR_W:0] w_last;
  logic            w_misal;
  logic [1:0]      w_lane;
  logic [31:0]     w_sh;
  logic            w_sext;

  always_comb begin
    w_lane  = i_addr[1:0];
    // One extra bit so the last byte address cannot wrap past the top of the space.
    w_last  = {1'b0, i_addr} + (ADDR_W+1)'(size_bytes(mem_size_e'(i_size))) - (ADDR_W+1)'(1);
    w_misal = 1'b1;
    case (i_size)
      MEM_B:   w_misal = 1'b0;
      MEM_H:   w_misal = i_addr[0];
      MEM_W:   w_misal = |i_addr[1:0];
      default: w_misal = 1'b1;
    endcase
    o_err = w_misal || (w_last >= LIMIT);

    // Lane 0 (lowest address) is the MSB of the stored word.
    w_sh    = i_raw << {w_lane, 3'b000};
    w_sext  = !i_unsigned && w_sh[31];
    o_be    = 4'b0000;
    o_wlane = 32'h0;
    o_rdata = 32'h0;
    case (i_size)
      MEM_B: begin
        o_be    = 4'b1000 >> w_lane;
        o_wlane = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_sext}}, w_sh[31:24]};
      end
      MEM_H: begin
        o_be    = w_lane[1] ? 4'b0011 : 4'b1100;
        o_wlane = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_sext}}, w_sh[31:16]};
      end
      MEM_W: begin
        o_be    = 4'b1111;
        o_wlane = i_wdata;
        o_rdata = i_raw;
      end
      default: ;
    endcase
    if (o_err) o_be = 4'b0000;
  end

endmodule

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - word-organised data memory with an RD_LAT-deep response pipe
// Define DMEM_TRACE_EN to print committed stores and errored requests.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 4096,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (DATA_W != DMEM_DATA_W) begin : g_bad_data_w
    $error("dmem_pipe: DATA_W must be 32");
  end
  if ((DEPTH_BYTES % 4) != 0 || DEPTH_BYTES < 4) begin : g_bad_depth
    $error("dmem_pipe: DEPTH_BYTES must be a non-zero multiple of 4");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("dmem_pipe: RD_LAT must be in 1..4");
  end

  // Legal accesses never straddle a word, so a word array with byte enables suffices.
  logic [31:0]      r_mem [WORDS];
  logic [RD_LAT-1:0] r_vld;
  dmem_rsp_t        r_rsp [RD_LAT];

  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_raw;
  logic             w_adv;
  logic             w_acc;
  logic             w_err;
  logic [3:0]       w_be;
  logic [31:0]      w_wlane;
  logic [31:0]      w_ld;

  assign w_idx     = req_addr[IDX_W+1:2];
  assign w_raw     = r_mem[w_idx];
  assign w_adv     = !rsp_valid || rsp_ready;
  assign req_ready = w_adv && !rst;
  assign w_acc     = req_valid && req_ready;

  dmem_align #(
    .ADDR_W      (ADDR_W),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_align (
    .i_addr     (req_addr),
    .i_size     (req_size),
    .i_unsigned (req_unsigned),
    .i_wdata    (req_wdata),
    .i_raw      (w_raw),
    .o_err      (w_err),
    .o_be       (w_be),
    .o_wlane    (w_wlane),
    .o_rdata    (w_ld)
  );

  always_ff @(posedge clk) begin
    if (w_acc && req_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_rsp[i] <= '0;
    end else if (w_adv) begin
      r_vld[0]       <= w_acc;
      r_rsp[0].rdata <= (w_acc && !req_we && !w_err) ? w_ld : 32'h0;
      r_rsp[0].err   <= w_acc && w_err;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_rsp[i] <= r_rsp[i-1];
      end
    end
  end

  assign rsp_valid = r_vld[RD_LAT-1];
  assign rsp_rdata = r_rsp[RD_LAT-1].rdata;
  assign rsp_err   = r_rsp[RD_LAT-1].err;

`ifdef DMEM_TRACE_EN
  logic [31:0] w_wr_just;
  assign w_wr_just = (req_size == MEM_B) ? {24'h0, req_wdata[7:0]} :
                     (req_size == MEM_H) ? {16'h0, req_wdata[15:0]} : req_wdata;

  always_ff @(posedge clk) begin
    if (w_acc && w_err)
      $display("DMEM err: [%h] size=%0d we=%0d", req_addr, req_size, req_we);
    else if (w_acc && req_we)
      $display("RAM write: [%h] <- %h size=%0d", req_addr, w_wr_just, req_size);
  end
`endif

endmodule

// File: tb/tb_dmem_pipe.sv
// tb/tb_dmem_pipe.sv - scoreboard bench for dmem_pipe at RD_LAT=1 and RD_LAT=3
module tb_dmem_pipe;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [31:0] req_addr     [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] prev_rd [2];
  bit          was_st  [2];

  always @(posedge clk) cyc <= cyc + 1;

  dmem_pipe #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_pipe #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(int d, logic we, logic [31:0] addr, logic [1:0] size, logic uns,
                       logic [31:0] wdata, logic [31:0] er, logic ee, bit chk);
    exp_t e;
    int   n = 0;
    req_we[d] = we; req_addr[d] = addr; req_size[d] = size;
    req_unsigned[d] = uns; req_wdata[d] = wdata; req_valid[d] = 1'b1;
    @(negedge clk);
    while (!req_ready[d] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready[d]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d addr %h: got ready=0 expected ready=1", d, addr);
    end else begin
      e.rdata = er; e.err = ee; e.acc = cyc; e.chk = chk;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      @(posedge clk);
    end
    #1 req_valid[d] = 1'b0;
  endtask

  task automatic mon(int d);
    exp_t e;
    int   lat = (d == 0) ? 1 : 3;
    if (rsp_valid[d] && !rsp_ready[d]) begin
      check($sformatf("stall_req_ready%0d", d), {31'h0, req_ready[d]}, 32'h0);
      if (was_st[d]) check($sformatf("stall_hold%0d", d), rsp_rdata[d], prev_rd[d]);
      prev_rd[d] = rsp_rdata[d];
      was_st[d]  = 1'b1;
    end else begin
      was_st[d]  = 1'b0;
    end
    if (rsp_valid[d] && rsp_ready[d]) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp dut%0d: got rdata %h expected no response", d, rsp_rdata[d]);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("rdata%0d", d), rsp_rdata[d], e.rdata);
        check($sformatf("err%0d", d), {31'h0, rsp_err[d]}, {31'h0, e.err});
        if (e.chk) check($sformatf("latency%0d", d), cyc, e.acc + lat);
      end
    end
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_size[d] = '0; req_unsigned[d] = 1'b0; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
      was_st[d] = 1'b0; prev_rd[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_rsp_valid", {31'h0, rsp_valid[d]}, 32'h0);
      check("reset_rsp_rdata", rsp_rdata[d], 32'h0);
      check("reset_rsp_err", {31'h0, rsp_err[d]}, 32'h0);
      check("reset_req_ready", {31'h0, req_ready[d]}, 32'h0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        issue(0, 1, 32'h10,  2, 0, 32'hDEADBEEF, 32'h0,        0, 1);
        issue(0, 0, 32'h10,  2, 0, 32'h0,        32'hDEADBEEF, 0, 1);
        issue(0, 0, 32'h10,  0, 0, 32'h0,        32'hFFFFFFDE, 0, 1);
        issue(0, 0, 32'h12,  1, 1, 32'h0,        32'h0000BEEF, 0, 1);
        issue(0, 1, 32'h20,  2, 0, 32'h11223344, 32'h0,        0, 1);
        issue(0, 1, 32'h21,  0, 0, 32'h0000007F, 32'h0,        0, 1);
        issue(0, 0, 32'h20,  2, 0, 32'h0,        32'h117F3344, 0, 1);
        issue(0, 1, 32'h30,  2, 0, 32'h55667788, 32'h0,        0, 1);
        issue(0, 1, 32'h31,  1, 0, 32'h0000AAAA, 32'h0,        1, 1);
        issue(0, 0, 32'h30,  2, 0, 32'h0,        32'h55667788, 0, 1);
        issue(0, 1, 32'hFFC, 2, 0, 32'hCAFEF00D, 32'h0,        0, 1);
        issue(0, 0, 32'hFFC, 2, 0, 32'h0,        32'hCAFEF00D, 0, 1);
        issue(0, 0, 32'hFFE, 2, 0, 32'h0,        32'h0,        1, 1);
        issue(0, 0, 32'hFFE, 1, 0, 32'h0,        32'hFFFFF00D, 0, 1);
        issue(0, 0, 32'hFFC, 1, 0, 32'h0,        32'hFFFFCAFE, 0, 1);
        issue(0, 0, 32'hFFF, 0, 1, 32'h0,        32'h0000000D, 0, 1);
        issue(0, 0, 32'h1000, 0, 0, 32'h0,       32'h0,        1, 1);
        issue(0, 0, 32'h0,   3, 0, 32'h0,        32'h0,        1, 1);
        issue(0, 1, 32'h50,  2, 0, 32'h12345678, 32'h0,        0, 1);
        issue(0, 0, 32'h50,  2, 0, 32'h0,        32'h12345678, 0, 1);
        issue(0, 0, 32'h52,  1, 0, 32'h0,        32'h00005678, 0, 1);
        issue(0, 0, 32'h51,  0, 0, 32'h0,        32'h00000034, 0, 1);
      end
      begin
        issue(1, 1, 32'h40, 2, 0, 32'hA1A2A3A4, 32'h0, 0, 1);
        issue(1, 1, 32'h44, 2, 0, 32'hB1B2B3B4, 32'h0, 0, 1);
        issue(1, 1, 32'h48, 2, 0, 32'hC1C2C3C4, 32'h0, 0, 1);
        issue(1, 1, 32'h4C, 2, 0, 32'hD1D2D3D4, 32'h0, 0, 1);
        repeat (6) @(posedge clk);
        #1 rsp_ready[1] = 1'b0;
        fork
          begin
            issue(1, 0, 32'h40, 2, 0, 32'h0, 32'hA1A2A3A4, 0, 0);
            issue(1, 0, 32'h44, 2, 0, 32'h0, 32'hB1B2B3B4, 0, 0);
            issue(1, 0, 32'h48, 2, 0, 32'h0, 32'hC1C2C3C4, 0, 0);
            issue(1, 0, 32'h4C, 2, 0, 32'h0, 32'hD1D2D3D4, 0, 0);
          end
          begin
            int n = 0;
            @(negedge clk);
            while (!rsp_valid[1] && n < 50) begin
              n++;
              @(negedge clk);
            end
            check("stall_first_rsp_seen", {31'h0, rsp_valid[1]}, 32'h1);
            repeat (2) @(posedge clk);
            #1 rsp_ready[1] = 1'b1;
          end
        join
        repeat (8) @(posedge clk);
        #1;
        issue(1, 0, 32'h40, 2, 0, 32'h0, 32'hA1A2A3A4, 0, 1);
        issue(1, 0, 32'h44, 2, 0, 32'h0, 32'hB1B2B3B4, 0, 1);
        rst[1] = 1'b1;
        #1;
        check("rst_drops_rsp_valid", {31'h0, rsp_valid[1]}, 32'h0);
        check("rst_req_ready", {31'h0, req_ready[1]}, 32'h0);
        q1.delete();
        @(posedge clk);
        #1 rst[1] = 1'b0;
        @(posedge clk);
        #1;
        issue(1, 0, 32'h48, 2, 0, 32'h0, 32'hC1C2C3C4, 0, 1);
      end
    join
    for (int n = 0; n < 50 && (q0.size() != 0 || q1.size() != 0); n++) @(posedge clk);
    @(negedge clk);
    check("pending_rsp_dut1", q0.size(), 0);
    check("pending_rsp_dut3", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
